// File: rtl/i2s_rx_if.sv
// Parallel PCM output of the I2S receiver: a stereo pair on a valid/ready handshake.
// With I2S_RX_MONO_MIX_EN defined, the interface also carries the mono downmix word.
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  sample_valid;
    logic                  sample_ready;
`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_WIDTH-1:0] mono_data;
`endif

    modport master (
`ifdef I2S_RX_MONO_MIX_EN
        output mono_data,
`endif
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
`ifdef I2S_RX_MONO_MIX_EN
        input  mono_data,
`endif
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_rx.sv
// Philips I2S receiver: deserialises sd/ws into left/right PCM words on a valid/ready port.
// Optional macro I2S_RX_MONO_MIX_EN adds a registered mono downmix output (floor((L+R)/2)).
//
// state  | meaning
// SYNC   | no frame alignment; waiting for the first ws edge
// WAIT_L | aligned to a left slot start; current slot becomes the staged left word
// RECV_R | receiving a right word; its close completes the pair
// RECV_L | receiving a left word; its close stages the left word
module i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 6
) (
    input  logic     bit_clk,
    input  logic     reset,
    input  logic     sd,
    input  logic     ws,
    output logic     overrun,
    input  logic     overrun_clr,
    output logic     locked,
    i2s_rx_if.master pcm
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        WAIT_L = 2'd1,
        RECV_R = 2'd2,
        RECV_L = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_SAT = CNT_WIDTH'(DATA_WIDTH);

    state_t                state;
    state_t                state_next;
    logic                  ws_d;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] left_stage;
    logic                  left_valid;
    logic                  ws_edge;
    logic                  zero_slot;
    logic                  cap_left;
    logic                  pair_done;

    assign ws_edge   = ws ^ ws_d;
    assign zero_slot = ws_edge && (bit_cnt == '0);

    // Bits land at their final left-aligned position, so short slots come out zero-padded
    // and anything past DATA_WIDTH shifts the mask out to nothing.
    assign word = sd ? (shift | (MSB_ONE >> bit_cnt)) : shift;

    assign locked = (state == RECV_R) || (state == RECV_L);

`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_WIDTH:0] mono_sum;
    assign mono_sum = {left_stage[DATA_WIDTH-1], left_stage} + {word[DATA_WIDTH-1], word};
`endif

    always_comb begin
        state_next = state;
        cap_left   = 1'b0;
        pair_done  = 1'b0;
        case (state)
            SYNC: begin
                if (ws_edge) begin
                    state_next = ws ? RECV_R : WAIT_L;
                end
            end
            WAIT_L, RECV_L: begin
                if (zero_slot) begin
                    state_next = SYNC;
                end else if (ws_edge && ws) begin
                    state_next = RECV_R;
                    cap_left   = 1'b1;
                end
            end
            RECV_R: begin
                if (zero_slot) begin
                    state_next = SYNC;
                end else if (ws_edge && !ws) begin
                    state_next = RECV_L;
                    pair_done  = left_valid;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge bit_clk or negedge reset) begin
        if (!reset) begin
            state            <= SYNC;
            ws_d             <= 1'b0;
            bit_cnt          <= '0;
            shift            <= '0;
            left_stage       <= '0;
            left_valid       <= 1'b0;
            overrun          <= 1'b0;
            pcm.left_data    <= '0;
            pcm.right_data   <= '0;
            pcm.sample_valid <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            pcm.mono_data    <= '0;
`endif
        end else begin
            state <= state_next;
            ws_d  <= ws;

            if (ws_edge) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else begin
                shift <= word;
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (cap_left) begin
                left_stage <= word;
            end

            // A pair is only emitted when its left half was seen from its first bit.
            if (state_next == SYNC) begin
                left_valid <= 1'b0;
            end else if (cap_left) begin
                left_valid <= 1'b1;
            end

            if (pair_done && (!pcm.sample_valid || pcm.sample_ready)) begin
                pcm.left_data    <= left_stage;
                pcm.right_data   <= word;
                pcm.sample_valid <= 1'b1;
`ifdef I2S_RX_MONO_MIX_EN
                pcm.mono_data    <= DATA_WIDTH'(mono_sum >> 1);
`endif
            end else if (pcm.sample_ready) begin
                pcm.sample_valid <= 1'b0;
            end

            if (pair_done && pcm.sample_valid && !pcm.sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a Philips I2S transmitter model drives directed frames,
// expected pairs are queued per frame and a monitor compares each accepted pair.
module tb_i2s_rx;

    localparam int DW = 16;

    logic bit_clk     = 1'b0;
    logic reset       = 1'b0;
    logic sd          = 1'b0;
    logic ws          = 1'b0;
    logic overrun_clr = 1'b0;
    logic overrun;
    logic locked;

    i2s_rx_if #(.DATA_WIDTH(DW)) pcm ();

    i2s_rx #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (6)
    ) dut (
        .bit_clk    (bit_clk),
        .reset      (reset),
        .sd         (sd),
        .ws         (ws),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .locked     (locked),
        .pcm        (pcm)
    );

    always #5 bit_clk = ~bit_clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] m;
        bit          mchk;
    } exp_t;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          n;
        logic [15:0] el;
        logic [15:0] er;
        logic [15:0] em;
        bit          mchk;
        bit          push;
        bit          rdy0;
        bit          rdy4;
        int          mode;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_bit = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [31:0] l, input logic [31:0] r, input int n,
                       input logic [15:0] el, input logic [15:0] er, input logic [15:0] em,
                       input bit mchk, input bit push, input bit rdy0, input bit rdy4,
                       input int mode);
        vec_t v;
        v.l = l; v.r = r; v.n = n; v.el = el; v.er = er; v.em = em;
        v.mchk = mchk; v.push = push; v.rdy0 = rdy0; v.rdy4 = rdy4; v.mode = mode;
        vecs.push_back(v);
    endtask

    // Philips framing: ws changes on the falling edge and data lags ws by one bit.
    task automatic send_frame(input vec_t v);
        exp_t        e;
        logic [31:0] w;
        if (v.push) begin
            e.l = v.el; e.r = v.er; e.m = v.em; e.mchk = v.mchk;
            sb.push_back(e);
        end
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? v.l : v.r;
            for (int i = 0; i < v.n; i++) begin
                @(negedge bit_clk);
                ws       = (ch == 1);
                sd       = prev_bit;
                prev_bit = w[v.n-1-i];
                if (ch == 0 && i == 0) pcm.sample_ready = v.rdy0;
                if (ch == 0 && i == 4) pcm.sample_ready = v.rdy4;
                if (v.mode == 1 && ch == 0) begin
                    if (i == 6) begin
                        #1;
                        check("overrun_set", overrun, 1);
                        check("held_left", pcm.left_data, 16'h1111);
                        check("held_valid", pcm.sample_valid, 1);
                        overrun_clr = 1'b1;
                    end
                    if (i == 7) overrun_clr = 1'b0;
                    if (i == 9) begin
                        #1;
                        check("overrun_clr", overrun, 0);
                    end
                end
                if (v.mode == 2 && ch == 0) begin
                    if (i == 1) begin
                        #1;
                        check("replace_valid", pcm.sample_valid, 1);
                        check("replace_left", pcm.left_data, 16'h7777);
                        check("replace_right", pcm.right_data, 16'h8888);
                    end
                    if (i == 3) begin
                        #1;
                        check("valid_cleared", pcm.sample_valid, 0);
                        check("no_overrun", overrun, 0);
                    end
                end
                if (v.mode == 3 && ch == 1) begin
                    if (i == 5) begin
                        reset = 1'b0;
                        #1;
                        check("midrst_locked", locked, 0);
                        check("midrst_valid", pcm.sample_valid, 0);
                        check("midrst_left", pcm.left_data, 0);
                        check("midrst_right", pcm.right_data, 0);
                        check("midrst_overrun", overrun, 0);
`ifdef I2S_RX_MONO_MIX_EN
                        check("midrst_mono", pcm.mono_data, 0);
`endif
                    end
                    if (i == 7) begin
                        reset = 1'b1;
                        #1;
                        check("release_locked", locked, 0);
                    end
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge bit_clk);
            #1;
            if (pcm.sample_valid && pcm.sample_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pair: got %h/%h, expected none", pcm.left_data,
                             pcm.right_data);
                end else begin
                    e = sb.pop_front();
                    check("left_data", pcm.left_data, e.l);
                    check("right_data", pcm.right_data, e.r);
`ifdef I2S_RX_MONO_MIX_EN
                    if (e.mchk) check("mono_data", pcm.mono_data, e.m);
`endif
                end
            end
        end
    end

    initial begin : stim
        pcm.sample_ready = 1'b1;
        //  l             r             n   el       er       em       mchk push rdy0 rdy4 mode
        add(32'hA5C3,     32'h1234,     16, 16'hA5C3, 16'h1234, 16'h0,    0,  0,   1,   1,   0);
        add(32'hA5C3,     32'h1234,     16, 16'hA5C3, 16'h1234, 16'h0,    0,  1,   1,   1,   0);
        add(32'h8001FFFF, 32'h7FFE0000, 32, 16'h8001, 16'h7FFE, 16'h0,    0,  1,   1,   1,   0);
        add(32'h8001FFFF, 32'h7FFE0000, 32, 16'h8001, 16'h7FFE, 16'h0,    0,  1,   1,   1,   0);
        add(32'hABC,      32'h123,      12, 16'hABC0, 16'h1230, 16'h0,    0,  1,   1,   1,   0);
        add(32'h1111,     32'h2222,     16, 16'h1111, 16'h2222, 16'h0,    0,  1,   1,   0,   0);
        add(32'h3333,     32'h4444,     16, 16'h3333, 16'h4444, 16'h0,    0,  0,   0,   0,   0);
        add(32'h5555,     32'h6666,     16, 16'h5555, 16'h6666, 16'h0,    0,  0,   0,   0,   0);
        add(32'h7777,     32'h8888,     16, 16'h7777, 16'h8888, 16'h0,    0,  1,   0,   0,   1);
        add(32'h9999,     32'hAAAA,     16, 16'h9999, 16'hAAAA, 16'h0,    0,  1,   1,   1,   2);
        add(32'h7FFF,     32'h0001,     16, 16'h7FFF, 16'h0001, 16'h4000, 1,  1,   1,   1,   0);
        add(32'h8000,     32'hFFFF,     16, 16'h8000, 16'hFFFF, 16'hBFFF, 1,  1,   1,   1,   0);
        add(32'h0F0F,     32'hF0F0,     16, 16'h0F0F, 16'hF0F0, 16'h0,    0,  0,   1,   1,   3);
        add(32'h1357,     32'h2468,     16, 16'h1357, 16'h2468, 16'h0,    0,  1,   1,   1,   0);
        add(32'h0246,     32'h8ACE,     16, 16'h0246, 16'h8ACE, 16'h0,    0,  1,   1,   1,   0);

        repeat (3) @(negedge bit_clk);
        #1;
        check("rst_left", pcm.left_data, 0);
        check("rst_right", pcm.right_data, 0);
        check("rst_valid", pcm.sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_locked", locked, 0);
`ifdef I2S_RX_MONO_MIX_EN
        check("rst_mono", pcm.mono_data, 0);
`endif
        @(negedge bit_clk);
        reset = 1'b1;
        repeat (4) @(negedge bit_clk);
        #1;
        check("idle_locked", locked, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            send_frame(vecs[k]);
            if (k == 0) begin
                #1;
                check("locked_after_first_right", locked, 1);
            end
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge bit_clk);
            ws       = 1'b0;
            sd       = prev_bit;
            prev_bit = 1'b0;
        end
        repeat (4) @(negedge bit_clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
